// File: rtl/wb_mailbox.sv
// Wishbone classic slave mailbox: host-to-local TX FIFO, local-to-host RX FIFO,
// status/control registers and a registered level interrupt.
module wb_mailbox #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  strobe,
    input  logic                  write,
    input  logic                  cycle,
    output logic                  ack,
    input  logic [3:0]            addr,
    input  logic [DATA_WIDTH-1:0] wrData,
    output logic [DATA_WIDTH-1:0] rdData,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  irq
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    localparam logic [3:0] ADDR_TXDATA  = 4'h0;
    localparam logic [3:0] ADDR_RXDATA  = 4'h1;
    localparam logic [3:0] ADDR_STATUS  = 4'h2;
    localparam logic [3:0] ADDR_CONTROL = 4'h3;

    logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [DEPTH_LOG2-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  irq_en_q, irq_en_d, irq_q, irq_d;

    logic req, bus_wr, bus_rd, ctrl_wr;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_flush, rx_flush, tx_pop, tx_push_req, tx_push, ovf_set;
    logic rx_push, rx_rd, rx_pop, unf_set;
    logic [DATA_WIDTH-1:0] rx_head, status;

    always_comb begin
        req      = cycle & strobe & ~ack_q;
        bus_wr   = req & write;
        bus_rd   = req & ~write;
        ctrl_wr  = bus_wr & (addr == ADDR_CONTROL);

        tx_full  = (tx_cnt_q == CW'(DEPTH));
        tx_empty = (tx_cnt_q == '0);
        rx_full  = (rx_cnt_q == CW'(DEPTH));
        rx_empty = (rx_cnt_q == '0);

        tx_flush = ctrl_wr & wrData[0];
        rx_flush = ctrl_wr & wrData[1];

        // A local pop in the same cycle frees the slot a full-FIFO bus push needs.
        tx_pop      = ~tx_empty & tx_ready;
        tx_push_req = bus_wr & (addr == ADDR_TXDATA);
        tx_push     = tx_push_req & (~tx_full | tx_pop);
        ovf_set     = tx_push_req & tx_full & ~tx_pop;

        rx_push = rx_valid & ~rx_full;
        rx_rd   = bus_rd & (addr == ADDR_RXDATA);
        rx_pop  = rx_rd & ~rx_empty;
        unf_set = rx_rd & rx_empty;

        rx_head = rx_empty ? '0 : rx_mem[rx_rp_q];

        status        = '0;
        status[0]     = tx_full;
        status[1]     = tx_empty;
        status[2]     = rx_full;
        status[3]     = rx_empty;
        status[4]     = ovf_q;
        status[5]     = unf_q;
        status[11:8]  = 4'(rx_cnt_q);
        status[15:12] = 4'(tx_cnt_q);
    end

    always_comb begin
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_flush) begin
            tx_wp_d  = '0;
            tx_rp_d  = '0;
            tx_cnt_d = '0;
        end else begin
            if (tx_push) tx_wp_d = tx_wp_q + DEPTH_LOG2'(1);
            if (tx_pop)  tx_rp_d = tx_rp_q + DEPTH_LOG2'(1);
            tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        end

        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        rx_cnt_d = rx_cnt_q;
        if (rx_flush) begin
            rx_wp_d  = '0;
            rx_rp_d  = '0;
            rx_cnt_d = '0;
        end else begin
            if (rx_push) rx_wp_d = rx_wp_q + DEPTH_LOG2'(1);
            if (rx_pop)  rx_rp_d = rx_rp_q + DEPTH_LOG2'(1);
            rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        end

        ovf_d    = ovf_set | (ovf_q & ~(ctrl_wr & wrData[4]));
        unf_d    = unf_set | (unf_q & ~(ctrl_wr & wrData[5]));
        irq_en_d = ctrl_wr ? wrData[8] : irq_en_q;
        irq_d    = irq_en_d & ((rx_cnt_d != '0) | ovf_d | unf_d);

        ack_d = req;
        rd_d  = '0;
        if (bus_rd) begin
            case (addr)
                ADDR_RXDATA:  rd_d    = rx_head;
                ADDR_STATUS:  rd_d    = status;
                ADDR_CONTROL: rd_d[8] = irq_en_q;
                default:      rd_d    = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push && !tx_flush) tx_mem[tx_wp_q] <= wrData;
        if (rx_push && !rx_flush) rx_mem[rx_wp_q] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
            ack_q    <= 1'b0;
            rd_q     <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            tx_cnt_q <= tx_cnt_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            rx_cnt_q <= rx_cnt_d;
            ack_q    <= ack_d;
            rd_q     <= rd_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign ack      = ack_q;
    assign rdData   = rd_q;
    assign irq      = irq_q;
    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_empty ? '0 : tx_mem[tx_rp_q];
    assign rx_ready = ~rx_full;

endmodule

// File: doc/wb_mailbox.md
# wb_mailbox

Wishbone classic slave occupying one 16-word address window behind the address-decoding interconnect. The window is 4 address bits wide. It bridges host bus transfers to a local streaming side through two FIFOs:
- TX: host writes, local side reads.
- RX: local side writes, host reads.

It provides status/control registers and a level interrupt, and is the responder end of the interconnect's slave port.

## Interface
- DATA_WIDTH, 16, bus and stream data width; must be ≥16 (status layout).
- DEPTH_LOG2, 3, log2 of each FIFO depth (default depth 8); must be ≤3 so counts fit 4 bits.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- strobe  in  1  Wishbone STB from interconnect.
- write  in  1  Wishbone WE.
- cycle  in  1  Wishbone CYC.
- ack  out  1  Wishbone ACK, registered, one-cycle pulse.
- addr  in  4  word address within window.
- wrData  in  DATA_WIDTH  write data.
- rdData  out  DATA_WIDTH  read data, registered, valid only while ack=1, else 0.
- tx_data  out  DATA_WIDTH  TX FIFO head; 0 when TX empty.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  local consumer pops head when tx_valid & tx_ready.
- rx_data  in  DATA_WIDTH  local producer data.
- rx_valid  in  1  local producer offers rx_data.
- rx_ready  out  1  RX FIFO not full; push when rx_valid & rx_ready.
- irq  out  1  registered level interrupt.

## Operation
- Request accepted in cycle where cycle & strobe & !ack. All side effects (push, pop, sticky set, control) occur at acceptance edge.
- Register map (unused addresses: read 0, write ignored, still acked):
  - 0x0 TXDATA, W: push wrData into TX FIFO. If full and no local pop same cycle: data dropped, TX_OVF set. Read returns 0, no effect.
  - 0x1 RXDATA, R: returns RX head and pops. If empty: returns 0, RX_UNF set. Write ignored.
  - 0x2 STATUS, R: bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 TX_OVF, bit5 RX_UNF, [11:8] rx_count, [15:12] tx_count, rest 0. Values are pre-edge state. Write ignored.
  - 0x3 CONTROL, W (write-1 actions except irq_en):
    - bit0 flush TX, bit1 flush RX.
    - bit4 clear TX_OVF, bit5 clear RX_UNF.
    - bit8 irq_en (stored).
    - Read returns irq_en at bit8, 0 elsewhere.
- FIFO counts range 0..2^DEPTH_LOG2. Pointers wrap modulo depth.
- Full TX FIFO + local pop + bus push in same cycle: push accepted, count unchanged.
- Empty RX FIFO + local push + bus pop in same cycle: no bypass; underflow returns 0, the local word is stored.
- Flush overrides same-cycle push/pop on that FIFO: count → 0, concurrent push discarded.
  - TX_OVF/RX_UNF have priority: a same-cycle set wins over a clear.
- irq is registered: irq = irq_en & (!rx_empty | TX_OVF | RX_UNF), using post-update state.

## Timing
- Reset values: ack 0, rdData 0, tx_valid 0, tx_data 0, rx_ready 1, irq 0. Also: FIFOs empty, stickies 0, irq_en 0. FIFO storage need not be reset.
- Assertion of rst mid-transfer: ack drops immediately; pending transfer lost.
- Bus latency: request sampled at edge N → ack=1 and rdData valid in cycle N+1 → ack=0 at N+2.
  - Held strobe gives one transfer per 2 cycles.
- If master drops cycle/strobe in cycle N+1, ack still pulses; side effect already committed.
- Stream sides are 0-latency combinational handshakes on registered FIFO state.
  - A pushed word is visible on tx_valid/tx_data the cycle after the push edge.
  - rx_ready updates the cycle after the count change.
- STATUS counts and irq reflect an update one cycle after the causing edge.

## Test plan
- Reset: hold rst=0 with strobe/cycle toggling → ack=0, tx_valid=0, rx_ready=1, irq=0. Release; read 0x2 → 0x000A.
- Write 0x1234, 0xBEEF to 0x0 with tx_ready=0 → STATUS tx_count=2. Raise tx_ready → tx_data 0x1234 then 0xBEEF, then tx_valid=0.
- Push 8 words to 0x0, then a 9th → 9th dropped, STATUS bit4=1. Write 0x0010 to 0x3 → bit4=0.
- Local pushes 0x00AA via rx_valid with irq_en=1 (write 0x0100 to 0x3) → irq=1. Read 0x1 → 0x00AA, then irq=0. Read 0x1 again → 0, RX_UNF=1, irq=1.
- Fill RX to 8 → rx_ready=0. Write 0x0002 to 0x3 in the same cycle as a local push attempt → rx_count=0, rx_ready=1.
- Hold strobe/cycle on a read of 0x2 → ack pattern 0,1,0,1. Assert rst during an ack cycle → ack=0 immediately, STATUS=0x000A after release.
